mc_ctrl: RTL

Multicycle main control unit for the MIPS datapath. Sequences every instruction through fetch/decode/execute/memory/writeback states and drives all datapath strobes. Produces the 3-bit `alu_op` consumed by the ALU control decoder: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 R-type/use funct. Waits on a ready handshake for every memory access.

---
 rtl/mc_ctrl_pkg.sv | 53 +++++
 rtl/mc_ctrl_out_dec.sv | 137 +++++++++++++
 rtl/mc_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle MIPS main control unit.
//   state_t      - FSM states (JAL is only reachable when MC_CTRL_JAL_EN is defined)
//   OP_* / FN_*  - opcode and funct constants
//   ALU_*        - alu_op codes for the ALU control decoder
//   RD_*, M2R_*, SRCB_*, PC_* - datapath mux selects
// Optional feature macro: MC_CTRL_JAL_EN (adds jal decode).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JR, S_JAL
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_FUNCT = 3'b110;

    localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;
    localparam logic [1:0] M2R_ALU = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10;
    localparam logic [1:0] SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH = 2'b11;
    localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10, PC_RS = 2'b11;

    // Opcodes the DECODE state can dispatch; anything else is flagged illegal.
    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: is_legal = 1'b1;
`ifdef MC_CTRL_JAL_EN
            OP_JAL:                                     is_legal = 1'b1;
`endif
            default:                                    is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_out_dec.sv
// mc_ctrl_out_dec: combinational state-to-strobes decoder.
// Inputs : rst_n (forces all strobes low), state, opcode, zero, mem_ready.
// Outputs: every datapath strobe of mc_ctrl (see mc_ctrl header).
// Optional feature macro: MC_CTRL_JAL_EN (JAL state strobes).
module mc_ctrl_out_dec
    import mc_ctrl_pkg::*;
(
    input  logic       rst_n,
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal
);

    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = RD_RT;
        mem_to_reg = M2R_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        ext_zero   = 1'b0;
        alu_op     = ALU_ADD;
        pc_src     = PC_ALU;
        instr_done = 1'b0;
        illegal    = 1'b0;
        // Strobes are gated by reset so an aborted access drops instantly.
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_rd    = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    // IR/PC only load on the cycle the fetch completes.
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM_SH;
                    if (!is_legal(opcode)) begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                S_R_WB: begin
                    reg_we     = 1'b1;
                    reg_dst    = RD_RD;
                    instr_done = 1'b1;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    case (opcode)
                        OP_ANDI: begin alu_op = ALU_AND; ext_zero = 1'b1; end
                        OP_ORI:  begin alu_op = ALU_OR;  ext_zero = 1'b1; end
                        OP_XORI: begin alu_op = ALU_XOR; ext_zero = 1'b1; end
                        OP_SLTI: alu_op = ALU_SLT;
                        default: alu_op = ALU_ADD;
                    endcase
                end
                S_I_WB: begin
                    reg_we     = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEM_RD: begin
                    mem_rd = 1'b1;
                    iord   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_we     = 1'b1;
                    mem_to_reg = M2R_MDR;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    mem_wr     = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem_ready;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_SUB;
                    pc_src     = PC_ALUOUT;
                    pc_we      = (opcode == OP_BNE) ? ~zero : zero;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_src     = PC_JUMP;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                end
                S_JR: begin
                    pc_src     = PC_RS;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                end
`ifdef MC_CTRL_JAL_EN
                S_JAL: begin
                    reg_we     = 1'b1;
                    reg_dst    = RD_RA;
                    mem_to_reg = M2R_PC;
                    pc_src     = PC_JUMP;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS main control unit. Sequences each instruction
// through fetch/decode/execute/memory/writeback and drives datapath strobes.
// Inputs : clk, rst_n (async, active low), opcode, funct, zero, mem_ready.
// Outputs: mem_rd, mem_wr, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg,
//          alu_src_a, alu_src_b, ext_zero, alu_op, pc_src, instr_done, illegal.
// Optional feature macro: MC_CTRL_JAL_EN (opcode 000011 decodes to JAL).
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal
);

    state_t state, state_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:    if (mem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:        state_nx = (funct == FN_JR) ? S_JR : S_EXEC_R;
                    OP_LW, OP_SW:    state_nx = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:  state_nx = S_BRANCH;
                    OP_J:            state_nx = S_JUMP;
`ifdef MC_CTRL_JAL_EN
                    OP_JAL:          state_nx = S_JAL;
`endif
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:
                                     state_nx = S_EXEC_I;
                    default:         state_nx = S_FETCH;
                endcase
            end
            S_EXEC_R:   state_nx = S_R_WB;
            S_EXEC_I:   state_nx = S_I_WB;
            S_MEM_ADDR: state_nx = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_nx = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) state_nx = S_FETCH;
            default:    state_nx = S_FETCH;
        endcase
    end

    mc_ctrl_out_dec u_out_dec (
        .rst_n      (rst_n),
        .state      (state),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_zero   (ext_zero),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

endmodule
